// File: rtl/life_row_engine.sv
// Streaming Game-of-Life row engine: one row in per handshake, next generation out.
// Keeps the rows above and at the current position so each new row completes the one before it.
module life_row_engine #(
  parameter int         WIDTH        = 16,
  parameter int         ROWS         = 16,
  parameter int         HWRAP        = 0,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
  localparam int        IW           = $clog2(ROWS)
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_row,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_row,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] dn;
  logic [WIDTH-1:0] nxt;
  logic [IW-1:0]    in_cnt;
  logic             slot_free;
  logic             fill_acc;
  logic             load;
  logic             last_load;

  // Bit 0 of the padded row is the left neighbour of column 0.
  function automatic logic [WIDTH+1:0] pad(input logic [WIDTH-1:0] v);
    logic lo;
    logic hi;
    lo  = (HWRAP != 0) ? v[WIDTH-1] : 1'b0;
    hi  = (HWRAP != 0) ? v[0] : 1'b0;
    pad = {hi, v, lo};
  endfunction

  function automatic logic [WIDTH-1:0] gen(
    input logic [WIDTH-1:0] up,
    input logic [WIDTH-1:0] mid,
    input logic [WIDTH-1:0] lo
  );
    logic [WIDTH+1:0] pu;
    logic [WIDTH+1:0] pm;
    logic [WIDTH+1:0] pl;
    logic [3:0]       n;
    logic [WIDTH-1:0] r;
    pu = pad(up);
    pm = pad(mid);
    pl = pad(lo);
    r  = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(pu[c]) + 4'(pu[c+1]) + 4'(pu[c+2])
        + 4'(pm[c]) + 4'(pm[c+2])
        + 4'(pl[c]) + 4'(pl[c+1]) + 4'(pl[c+2]);
      r[c] = mid[c] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
    end
    return r;
  endfunction

  assign slot_free = !out_valid || out_ready;
  // Row below the last row of the frame is always dead.
  assign dn        = (state == FLUSH) ? '0 : in_row;
  assign nxt       = gen(prev, cur, dn);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= nstate;
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    fill_acc  = 1'b0;
    load      = 1'b0;
    last_load = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fill_acc = 1'b1;
          nstate   = RUN;
        end
      end
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          load = 1'b1;
          if (in_cnt == IW'(ROWS-1)) nstate = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load      = 1'b1;
          last_load = 1'b1;
          nstate    = FILL;
        end
      end
      default: nstate = FILL;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      cur        <= '0;
      in_cnt     <= '0;
      out_row    <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (fill_acc) begin
        cur    <= in_row;
        prev   <= '0;
        in_cnt <= IW'(1);
      end
      if (load && !last_load) begin
        prev <= cur;
        cur  <= in_row;
        if (in_cnt != IW'(ROWS-1)) in_cnt <= in_cnt + 1'b1;
      end
      if (last_load) in_cnt <= '0;
      if (load) begin
        out_row   <= nxt;
        out_idx   <= last_load ? IW'(ROWS-1) : in_cnt - 1'b1;
        out_last  <= last_load;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
